stage_router: RTL and testbench
===============================

Name: stage_router

Overview:
- Parametrised successor to the game-level stage multiplexer.
- Selects the LED-matrix RGB bits, buzzer controls and stage-flow flags of one of NUM_STAGES stage engines according to cur_stage, and registers them.
- Owns switch conditioning (synchronise, debounce, rising-edge detect) for NUM_SW push switches.
- New capability: enforces a blanking window on every stage change, so a stale frame, sound or button press never leaks into the new stage.

Parameters:
- NUM_STAGES, 5, number of stage engines; must be at least 2.
- STG_W, $clog2(NUM_STAGES), width of cur_stage and next_stage_flag.
- NUM_SW, 4, number of push switches.
- DEB_CYCLES, 8, consecutive differing samples required to accept a switch change; must be at least 1.
- NOTE_W, 4, note_sel width.
- SEL_W, 2, stage_select width.
- BLANK_CYCLES, 4, blanking length in clocks; 0 disables blanking.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- cur_stage, in, STG_W, active stage index.
- sw_in, in, NUM_SW, raw asynchronous switch pins.
- sw_level, out, NUM_SW, debounced switch levels.
- sw_rise, out, NUM_SW, one-cycle rising-edge pulses to the stage engines.
- st_rgb, in, NUM_STAGES*6, per-stage {RU,RD,GU,GD,BU,BD}; stage s occupies bits [6s+5:6s].
- st_sound_en, in, NUM_STAGES, per-stage sound enable.
- st_note_sel, in, NUM_STAGES*NOTE_W, per-stage note select.
- st_next_flag, in, NUM_STAGES*STG_W, per-stage next-stage request.
- st_select, in, NUM_STAGES*SEL_W, per-stage stage_select.
- rgb_out, out, 6, registered RGB bits, same packing as st_rgb.
- sound_en, out, 1, registered sound enable to the buzzer.
- note_sel, out, NUM_STAGES-independent NOTE_W, registered note select to the buzzer.
- next_stage_flag, out, STG_W, registered next-stage request.
- stage_select, out, SEL_W, registered stage_select.
- blank_busy, out, 1, high while the blanking window is active.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - all outputs to 0;
  - sync flops, debounce counters and debounced levels to 0;
  - the registered stage copy cur_q to 0;
  - the blank counter to 0.
  - No blanking window follows reset.
- Switch path, per switch (one sw_debounce instance each):
  - 2-flop synchroniser, then a counter of consecutive cycles in which the synchronised value differs from the stable level.
  - The counter clears whenever they agree.
  - On the DEB_CYCLES-th consecutive differing edge, the stable level takes the synchronised value and the counter clears.
  - Latency from a clean pin edge to a sw_level change: 2+DEB_CYCLES clocks.
  - sw_rise is registered. It is high for exactly one cycle, in the same cycle sw_level first reads 1.
- Stage select:
  - idx = cur_stage if cur_stage < NUM_STAGES, else 0 (opening).
  - Output registers load stage idx's slices every clock.
  - Latency is 1 clock from the input slice to the output.
- Change detect: chg = (cur_stage != cur_q); cur_q <= cur_stage every clock.
- Blanking (BLANK_CYCLES > 0):
  - On an edge where chg=1, the blank counter loads BLANK_CYCLES.
  - The output registers hold blank values for exactly BLANK_CYCLES clocks, starting at that edge.
  - The following edge loads the new stage's values.
  - Blank values: rgb_out=0, sound_en=0, note_sel=0, next_stage_flag=0.
  - stage_select is never blanked; it follows the mux.
  - blank_busy is high for exactly the same BLANK_CYCLES cycles.
  - sw_rise is forced to 0 during those cycles. Masked pulses are dropped, not deferred; sw_level keeps updating.
  - A further change while blanking reloads the counter, so the window restarts.
- BLANK_CYCLES=0: no blanking, blank_busy stays 0, and the change takes effect with the normal 1-clock latency.
- A simultaneous switch rise and stage change: the rise is masked.
- Reset mid-window: the window aborts and outputs are 0.

Decomposition:
- Shared package holds:
  - stage code constants: OPENING=0, STAGE1=1, STAGE2=2, STAGE3=3, FINISH=4;
  - RGB bit-index constants: RU=5, RD=4, GU=3, GD=2, BU=1, BD=0;
  - default NOTE_W and SEL_W.
- Sub-module sw_debounce (parameter DEB_CYCLES): one switch's synchroniser, counter, stable level and registered rise pulse. Instantiate it with a generate loop over NUM_SW.

Test Plan:
- Hold reset=0 mid-operation with stage 2 active → all outputs 0 asynchronously. Release reset → no blank_busy; stage 0 values appear 1 clock later.
- cur_stage=2 steady, st_rgb slice 2 = 6'b101010, st_note_sel slice 2 = 4'd9 → rgb_out=101010 and note_sel=9 one clock after the inputs are applied.
- BLANK_CYCLES=4, cur_stage 1→3 → rgb_out, sound_en and next_stage_flag all 0 for 4 cycles, blank_busy high for 4 cycles, then stage 3 values. A second change at blank cycle 2 extends the window to 6 cycles total.
- cur_stage=7 with NUM_STAGES=5 → outputs equal stage 0's slices.
- DEB_CYCLES=8, sw_in[1] toggling every 3 clocks for 30 clocks then held high → no sw_rise during bouncing; exactly one sw_rise[1] pulse, 10 clocks after the final rising pin edge.
- Clean press of sw_in[0] timed so its rise lands inside the blank window → sw_level[0]=1 but no sw_rise[0] pulse, and none after the window ends.

Source files
------------

// File: rtl/stage_router_pkg.sv
// ---------------------------------------------------------------------------
// stage_router_pkg
// Shared constants for the stage router and its switch conditioning.
//   - stage codes used by the game-level stage engines
//   - bit positions inside the 6-bit {RU,RD,GU,GD,BU,BD} RGB word
//   - default widths for the buzzer note select and stage_select fields
//   - cntWidth(): counter width needed to hold 0..maxVal (never below 1)
// ---------------------------------------------------------------------------
package stage_router_pkg;

    // Stage codes carried on cur_stage / next_stage_flag
    localparam logic [2:0] OPENING = 3'd0;
    localparam logic [2:0] STAGE1  = 3'd1;
    localparam logic [2:0] STAGE2  = 3'd2;
    localparam logic [2:0] STAGE3  = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    // Bit positions in one stage's RGB slice
    localparam int RU = 5;
    localparam int RD = 4;
    localparam int GU = 3;
    localparam int GD = 2;
    localparam int BU = 1;
    localparam int BD = 0;
    localparam int RGB_W = 6;

    // Default field widths
    localparam int NOTE_W_DEF = 4;
    localparam int SEL_W_DEF  = 2;

    // Width of a counter that must hold every value from 0 to maxVal
    function automatic int cntWidth(input int maxVal);
        if (maxVal <= 1) begin
            return 1;
        end
        return $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Conditions one raw push switch: 2-flop synchroniser, consecutive-difference
// debounce counter, stable level and a registered one-cycle rising pulse.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-low reset
//   sw_i     - raw asynchronous switch pin
//   level_o  - debounced switch level
//   rise_o   - one-cycle pulse, high in the cycle level_o first reads 1
// ---------------------------------------------------------------------------
module sw_debounce
    import stage_router_pkg::*;
#(
    parameter int DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = cntWidth(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;

    // The stable level only moves after DEB_CYCLES consecutive edges on which
    // the synchronised pin disagrees with it; any agreement restarts the count.
    // The rise pulse is computed here so it lines up with the level update.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser flops plus the debounce state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/stage_router.sv
// ---------------------------------------------------------------------------
// stage_router
// Routes the LED, buzzer and stage-flow outputs of the active stage engine to
// registered outputs, conditions the push switches, and blanks outputs and
// switch pulses for BLANK_CYCLES clocks after every stage change.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   cur_stage         - active stage index (out-of-range selects stage 0)
//   sw_in             - raw switch pins
//   sw_level, sw_rise - debounced levels, masked one-cycle rising pulses
//   st_*              - per-stage packed slices from the stage engines
//   rgb_out, sound_en, note_sel, next_stage_flag, stage_select
//                     - registered outputs of the selected stage
//   blank_busy        - high while the blanking window is active
// ---------------------------------------------------------------------------
module stage_router
    import stage_router_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int STG_W        = $clog2(NUM_STAGES),
    parameter int NUM_SW       = 4,
    parameter int DEB_CYCLES   = 8,
    parameter int NOTE_W       = NOTE_W_DEF,
    parameter int SEL_W        = SEL_W_DEF,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [STG_W-1:0]             cur_stage,
    input  logic [NUM_SW-1:0]            sw_in,
    output logic [NUM_SW-1:0]            sw_level,
    output logic [NUM_SW-1:0]            sw_rise,
    input  logic [NUM_STAGES*RGB_W-1:0]  st_rgb,
    input  logic [NUM_STAGES-1:0]        st_sound_en,
    input  logic [NUM_STAGES*NOTE_W-1:0] st_note_sel,
    input  logic [NUM_STAGES*STG_W-1:0]  st_next_flag,
    input  logic [NUM_STAGES*SEL_W-1:0]  st_select,
    output logic [RGB_W-1:0]             rgb_out,
    output logic                         sound_en,
    output logic [NOTE_W-1:0]            note_sel,
    output logic [STG_W-1:0]             next_stage_flag,
    output logic [SEL_W-1:0]             stage_select,
    output logic                         blank_busy
);

    localparam int BLK_W = cntWidth(BLANK_CYCLES);

    logic [NUM_SW-1:0] riseRaw;

    logic [RGB_W-1:0]  rgbSel;
    logic              soundSel;
    logic [NOTE_W-1:0] noteSel;
    logic [STG_W-1:0]  nextSel;
    logic [SEL_W-1:0]  selSel;

    logic [STG_W-1:0]  cur_q;
    logic              chg;
    logic [BLK_W-1:0]  blankCnt_q;
    logic [BLK_W-1:0]  blankCnt_d;
    logic              blankNext;

    logic [RGB_W-1:0]  rgb_q;
    logic [RGB_W-1:0]  rgb_d;
    logic              sound_q;
    logic              sound_d;
    logic [NOTE_W-1:0] note_q;
    logic [NOTE_W-1:0] note_d;
    logic [STG_W-1:0]  next_q;
    logic [STG_W-1:0]  next_d;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_d;

    // One conditioner per switch
    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        sw_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .sw_i    (sw_in[i]),
            .level_o (sw_level[i]),
            .rise_o  (riseRaw[i])
        );
    end

    // Stage mux: stage 0 is the fallback, so any cur_stage that matches no
    // engine (out of range) lands on the opening stage.
    always_comb begin
        rgbSel   = st_rgb[RGB_W-1:0];
        soundSel = st_sound_en[0];
        noteSel  = st_note_sel[NOTE_W-1:0];
        nextSel  = st_next_flag[STG_W-1:0];
        selSel   = st_select[SEL_W-1:0];
        for (int s = 1; s < NUM_STAGES; s++) begin
            if (cur_stage == STG_W'(s)) begin
                rgbSel   = st_rgb[s*RGB_W +: RGB_W];
                soundSel = st_sound_en[s];
                noteSel  = st_note_sel[s*NOTE_W +: NOTE_W];
                nextSel  = st_next_flag[s*STG_W +: STG_W];
                selSel   = st_select[s*SEL_W +: SEL_W];
            end
        end
    end

    // Blank counter next state. A stage change (re)loads the full window;
    // otherwise it counts down to zero. blankNext tells the output registers
    // whether the cycle being loaded still lies inside the window, which
    // keeps blanked outputs and blank_busy exactly aligned.
    assign chg = (cur_stage != cur_q);

    always_comb begin
        blankCnt_d = '0;
        if (BLANK_CYCLES != 0) begin
            if (chg) begin
                blankCnt_d = BLK_W'(BLANK_CYCLES);
            end else if (blankCnt_q != '0) begin
                blankCnt_d = blankCnt_q - BLK_W'(1);
            end
        end
    end

    assign blankNext = (blankCnt_d != '0);

    // Output register inputs; stage_select deliberately bypasses blanking
    always_comb begin
        rgb_d   = blankNext ? '0   : rgbSel;
        sound_d = blankNext ? 1'b0 : soundSel;
        note_d  = blankNext ? '0   : noteSel;
        next_d  = blankNext ? '0   : nextSel;
        sel_d   = selSel;
    end

    // Stage copy, blank counter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_q      <= '0;
            blankCnt_q <= '0;
            rgb_q      <= '0;
            sound_q    <= 1'b0;
            note_q     <= '0;
            next_q     <= '0;
            sel_q      <= '0;
        end else begin
            cur_q      <= cur_stage;
            blankCnt_q <= blankCnt_d;
            rgb_q      <= rgb_d;
            sound_q    <= sound_d;
            note_q     <= note_d;
            next_q     <= next_d;
            sel_q      <= sel_d;
        end
    end

    assign blank_busy      = (blankCnt_q != '0);
    assign sw_rise         = riseRaw & ~{NUM_SW{blank_busy}};
    assign rgb_out         = rgb_q;
    assign sound_en        = sound_q;
    assign note_sel        = note_q;
    assign next_stage_flag = next_q;
    assign stage_select    = sel_q;

endmodule

// File: tb/tb_stage_router.sv
// ---------------------------------------------------------------------------
// tb_stage_router
// Self-checking bench for stage_router. Expected output values are queued
// with the clock cycle they are due in and compared by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_stage_router;

    localparam int NUM_STAGES   = 5;
    localparam int STG_W        = 3;
    localparam int NUM_SW       = 4;
    localparam int DEB_CYCLES   = 8;
    localparam int NOTE_W       = 4;
    localparam int SEL_W        = 2;
    localparam int BLANK_CYCLES = 4;

    localparam int F_RGB   = 0;
    localparam int F_SOUND = 1;
    localparam int F_NOTE  = 2;
    localparam int F_NEXT  = 3;
    localparam int F_SEL   = 4;
    localparam int F_BUSY  = 5;
    localparam int F_LEVEL = 6;
    localparam int F_RISE  = 7;

    logic                         clk;
    logic                         reset;
    logic [STG_W-1:0]             cur_stage;
    logic [NUM_SW-1:0]            sw_in;
    logic [NUM_SW-1:0]            sw_level;
    logic [NUM_SW-1:0]            sw_rise;
    logic [NUM_STAGES*6-1:0]      st_rgb;
    logic [NUM_STAGES-1:0]        st_sound_en;
    logic [NUM_STAGES*NOTE_W-1:0] st_note_sel;
    logic [NUM_STAGES*STG_W-1:0]  st_next_flag;
    logic [NUM_STAGES*SEL_W-1:0]  st_select;
    logic [5:0]                   rgb_out;
    logic                         sound_en;
    logic [NOTE_W-1:0]            note_sel;
    logic [STG_W-1:0]             next_stage_flag;
    logic [SEL_W-1:0]             stage_select;
    logic                         blank_busy;

    // Per-stage reference values driven onto the stage engine buses
    logic [5:0]        rgbTab   [NUM_STAGES] = '{6'b000001, 6'b110011, 6'b101010, 6'b011100, 6'b111111};
    logic [NOTE_W-1:0] noteTab  [NUM_STAGES] = '{4'd1, 4'd5, 4'd9, 4'd12, 4'd15};
    logic              soundTab [NUM_STAGES] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [STG_W-1:0]  nextTab  [NUM_STAGES] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [SEL_W-1:0]  selTab   [NUM_STAGES] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};

    typedef struct {
        int          due;
        int          fld;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sbQ[$];
    int   cyc = 0;
    int   checkCount = 0;
    int   errCount = 0;

    stage_router #(
        .NUM_STAGES   (NUM_STAGES),
        .STG_W        (STG_W),
        .NUM_SW       (NUM_SW),
        .DEB_CYCLES   (DEB_CYCLES),
        .NOTE_W       (NOTE_W),
        .SEL_W        (SEL_W),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cur_stage       (cur_stage),
        .sw_in           (sw_in),
        .sw_level        (sw_level),
        .sw_rise         (sw_rise),
        .st_rgb          (st_rgb),
        .st_sound_en     (st_sound_en),
        .st_note_sel     (st_note_sel),
        .st_next_flag    (st_next_flag),
        .st_select       (st_select),
        .rgb_out         (rgb_out),
        .sound_en        (sound_en),
        .note_sel        (note_sel),
        .next_stage_flag (next_stage_flag),
        .stage_select    (stage_select),
        .blank_busy      (blank_busy)
    );

    // Free-running clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic logic [31:0] fieldVal(input int fld);
        case (fld)
            F_RGB:   return 32'(rgb_out);
            F_SOUND: return 32'(sound_en);
            F_NOTE:  return 32'(note_sel);
            F_NEXT:  return 32'(next_stage_flag);
            F_SEL:   return 32'(stage_select);
            F_BUSY:  return 32'(blank_busy);
            F_LEVEL: return 32'(sw_level);
            F_RISE:  return 32'(sw_rise);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Scoreboard monitor: compare every entry due in this cycle, mid-cycle
    always @(negedge clk) begin
        for (int i = sbQ.size() - 1; i >= 0; i--) begin
            if (sbQ[i].due == cyc) begin
                checkOutput(sbQ[i].tag, fieldVal(sbQ[i].fld), sbQ[i].val);
                sbQ.delete(i);
            end
        end
    end

    task automatic expectVal(input string tag, input int fld, input int delay, input logic [31:0] val);
        exp_t e;
        e.due = cyc + delay;
        e.fld = fld;
        e.val = val;
        e.tag = $sformatf("%s_f%0d_d%0d", tag, fld, delay);
        sbQ.push_back(e);
    endtask

    task automatic expectStage(input string tag, input int s, input int delay);
        expectVal(tag, F_RGB,   delay, 32'(rgbTab[s]));
        expectVal(tag, F_SOUND, delay, 32'(soundTab[s]));
        expectVal(tag, F_NOTE,  delay, 32'(noteTab[s]));
        expectVal(tag, F_NEXT,  delay, 32'(nextTab[s]));
        expectVal(tag, F_SEL,   delay, 32'(selTab[s]));
        expectVal(tag, F_BUSY,  delay, 32'd0);
    endtask

    task automatic expectBlank(input string tag, input int s, input int delay);
        expectVal(tag, F_RGB,   delay, 32'd0);
        expectVal(tag, F_SOUND, delay, 32'd0);
        expectVal(tag, F_NOTE,  delay, 32'd0);
        expectVal(tag, F_NEXT,  delay, 32'd0);
        expectVal(tag, F_SEL,   delay, 32'(selTab[s]));
        expectVal(tag, F_BUSY,  delay, 32'd1);
    endtask

    // Full window after a change to stage s, then the stage's own values
    task automatic expectWindow(input string tag, input int s);
        for (int d = 1; d <= BLANK_CYCLES; d++) expectBlank(tag, s, d);
        expectStage(tag, s, BLANK_CYCLES + 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rgb"},   32'(rgb_out), 32'd0);
        checkOutput({tag, "_sound"}, 32'(sound_en), 32'd0);
        checkOutput({tag, "_note"},  32'(note_sel), 32'd0);
        checkOutput({tag, "_next"},  32'(next_stage_flag), 32'd0);
        checkOutput({tag, "_sel"},   32'(stage_select), 32'd0);
        checkOutput({tag, "_busy"},  32'(blank_busy), 32'd0);
        checkOutput({tag, "_level"}, 32'(sw_level), 32'd0);
        checkOutput({tag, "_rise"},  32'(sw_rise), 32'd0);
    endtask

    task automatic applyStimulus(input logic [STG_W-1:0] stg, input logic [NUM_SW-1:0] sw);
        cur_stage = stg;
        sw_in     = sw;
    endtask

    // Advance n clocks, landing 2 time units after the posedge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(3'd0, 4'b0000);
        for (int s = 0; s < NUM_STAGES; s++) begin
            st_rgb[s*6 +: 6]            = rgbTab[s];
            st_sound_en[s]              = soundTab[s];
            st_note_sel[s*NOTE_W +: NOTE_W] = noteTab[s];
            st_next_flag[s*STG_W +: STG_W]  = nextTab[s];
            st_select[s*SEL_W +: SEL_W]     = selTab[s];
        end
        #1 reset = 1'b0;
        step(3);
        checkAllZero("rst_init");

        // Release: no window, stage 0 one clock later
        reset = 1'b1;
        expectStage("rel", 0, 1);
        expectVal("rel", F_BUSY, 2, 32'd0);
        step(3);

        // Change to stage 2, then slice updates with 1-clock latency
        applyStimulus(3'd2, 4'b0000);
        expectWindow("to2", 2);
        step(6);
        st_rgb[12 +: 6]     = 6'b010101;
        st_note_sel[8 +: 4] = 4'd3;
        expectVal("slice_a", F_RGB, 1, 32'b010101);
        expectVal("slice_a", F_NOTE, 1, 32'd3);
        step(1);
        st_rgb[12 +: 6]     = 6'b101010;
        st_note_sel[8 +: 4] = 4'd9;
        expectVal("slice_b", F_RGB, 1, 32'b101010);
        expectVal("slice_b", F_NOTE, 1, 32'd9);
        step(2);

        // 2 -> 1 -> 3 with full windows
        applyStimulus(3'd1, 4'b0000);
        expectWindow("to1", 1);
        step(6);
        applyStimulus(3'd3, 4'b0000);
        expectWindow("to3", 3);
        step(6);

        // 3 -> 1, then 1 -> 4 in blank cycle 2: six blank cycles in total
        applyStimulus(3'd1, 4'b0000);
        expectBlank("re_a", 1, 1);
        expectBlank("re_a", 1, 2);
        step(2);
        applyStimulus(3'd4, 4'b0000);
        expectWindow("re_b", 4);
        step(6);

        // Out-of-range stage falls back to stage 0
        applyStimulus(3'd7, 4'b0000);
        expectWindow("oor", 0);
        expectStage("oor", 0, BLANK_CYCLES + 2);
        step(7);

        // Bouncing sw_in[1] for 30 clocks, then held high
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0) applyStimulus(3'd7, {2'b00, ((c / 3) % 2 == 0), 1'b0});
            expectVal("bnc", F_RISE, 1, 32'd0);
            expectVal("bnc", F_LEVEL, 1, 32'd0);
            step(1);
        end
        applyStimulus(3'd7, 4'b0010);
        for (int d = 1; d <= 9; d++) expectVal("hold", F_RISE, d, 32'd0);
        expectVal("hold", F_LEVEL, 9, 32'd0);
        expectVal("hold", F_LEVEL, 10, 32'b0010);
        expectVal("hold", F_RISE, 10, 32'b0010);
        expectVal("hold", F_RISE, 11, 32'd0);
        expectVal("hold", F_LEVEL, 12, 32'b0010);
        step(13);

        // Clean press of sw_in[0] whose rise lands inside a window
        applyStimulus(3'd7, 4'b0011);
        step(7);
        applyStimulus(3'd0, 4'b0011);
        expectWindow("mask", 0);
        expectVal("mask", F_LEVEL, 2, 32'b0010);
        expectVal("mask", F_LEVEL, 3, 32'b0011);
        expectVal("mask", F_LEVEL, 6, 32'b0011);
        for (int d = 1; d <= 7; d++) expectVal("mask", F_RISE, d, 32'd0);
        step(8);

        // sw_in[2] rise coinciding with the stage-change edge
        applyStimulus(3'd0, 4'b0111);
        step(9);
        applyStimulus(3'd1, 4'b0111);
        expectVal("simul", F_LEVEL, 1, 32'b0111);
        expectVal("simul", F_BUSY, 1, 32'd1);
        for (int d = 1; d <= 5; d++) expectVal("simul", F_RISE, d, 32'd0);
        step(6);

        // Reset with stage 2 settled
        applyStimulus(3'd2, 4'b0000);
        expectWindow("pre_rst", 2);
        step(8);
        #1 reset = 1'b0;
        #1 checkAllZero("rst_mid");
        step(1);
        applyStimulus(3'd0, 4'b0000);
        reset = 1'b1;
        expectStage("rel2", 0, 1);
        expectVal("rel2", F_BUSY, 2, 32'd0);
        step(3);

        // Reset in the middle of a window aborts it
        applyStimulus(3'd2, 4'b0000);
        expectBlank("win", 2, 1);
        step(2);
        #1 reset = 1'b0;
        #1 checkAllZero("rst_win");
        step(1);
        applyStimulus(3'd0, 4'b0000);
        reset = 1'b1;
        expectStage("rel3", 0, 1);
        expectVal("rel3", F_BUSY, 2, 32'd0);
        step(4);

        checkOutput("sb_drain", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
